// File: rtl/draw_pkg.sv
// Shared state encoding, mode selects and geometry for the drawing sequencer.
package draw_pkg;

    localparam int unsigned SCR_W    = 160;
    localparam int unsigned SCR_H    = 120;
    localparam int unsigned SPR_DIM  = 40;
    localparam int unsigned PIPE_LAT = 2;

    localparam logic [1:0] XY_SCREEN = 2'b00;
    localparam logic [1:0] XY_SPRITE = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PRIME,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/pixel_walker.sv
// Column/row position of the pixel being plotted. Wraps at the edge of the
// active region: 160x120 for a screen, 40x40 for a sprite.
module pixel_walker
    import draw_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic step,
    input  logic sprite,
    output logic col_last,
    output logic row_last
);

    logic [7:0] col_q, col_d;
    logic [6:0] row_q, row_d;
    logic [7:0] col_max;
    logic [6:0] row_max;

    assign col_max  = sprite ? 8'(SPR_DIM - 1) : 8'(SCR_W - 1);
    assign row_max  = sprite ? 7'(SPR_DIM - 1) : 7'(SCR_H - 1);
    assign col_last = (col_q == col_max);
    assign row_last = (row_q == row_max);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 7'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Control FSM for the drawing datapath: one screen or sprite draw per
// req/ack/done handshake, plus the independent player score strobes.
module draw_sequencer
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_sprite,
    input  logic       req_erase,
    input  logic [4:0] req_mem,
    input  logic [4:0] req_xsel,
    input  logic [1:0] req_ysel,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    input  logic       screenDone,
    output logic       ack,
    output logic       done,
    output logic       busy,
    output logic       plot,
    output logic       xInitReset,
    output logic       xInitLoad,
    output logic       yInitReset,
    output logic       yInitLoad,
    output logic       xReset,
    output logic       xLoad,
    output logic       xCountUp,
    output logic       yReset,
    output logic       yLoad,
    output logic       yCountUp,
    output logic [1:0] xySel,
    output logic [4:0] xInitSel,
    output logic [1:0] yInitSel,
    output logic [4:0] memorySel,
    output logic       black,
    output logic       addressScreenCounterReset,
    output logic       screenCountLoad,
    output logic       addressSpriteCounterReset,
    output logic       spriteCountLoad,
    output logic       playerReset,
    output logic       playerLoad,
    output logic       winner1,
    output logic       winner2
);

    state_t     state_q, state_d;
    logic [1:0] prime_q, prime_d;
    logic       sprite_q, sprite_d;
    logic       black_q, black_d;
    logic [4:0] mem_q, mem_d;
    logic [4:0] xsel_q, xsel_d;
    logic [1:0] ysel_q, ysel_d;
    logic       count_load;
    logic       walk_clear;
    logic       walk_step;
    logic       col_last;
    logic       row_last;

    logic       player_reset_q, player_reset_d;
    logic       player_load_q, player_load_d;
    logic       winner1_q, winner1_d;
    logic       winner2_q, winner2_d;

    pixel_walker u_walker (
        .clk      (clk),
        .reset    (reset),
        .clear    (walk_clear),
        .step     (walk_step),
        .sprite   (sprite_q),
        .col_last (col_last),
        .row_last (row_last)
    );

    // Origin registers are always reloaded from the select muxes; never cleared here.
    assign xInitReset = 1'b0;
    assign yInitReset = 1'b0;
    assign yLoad      = 1'b0;

    assign busy            = (state_q != IDLE);
    assign xySel           = sprite_q ? XY_SPRITE : XY_SCREEN;
    assign xInitSel        = xsel_q;
    assign yInitSel        = ysel_q;
    assign memorySel       = mem_q;
    assign black           = black_q;
    assign screenCountLoad = count_load & ~sprite_q;
    assign spriteCountLoad = count_load & sprite_q;

    always_comb begin
        state_d                   = state_q;
        prime_d                   = prime_q;
        sprite_d                  = sprite_q;
        black_d                   = black_q;
        mem_d                     = mem_q;
        xsel_d                    = xsel_q;
        ysel_d                    = ysel_q;
        ack                       = 1'b0;
        done                      = 1'b0;
        plot                      = 1'b0;
        xInitLoad                 = 1'b0;
        yInitLoad                 = 1'b0;
        xReset                    = 1'b0;
        yReset                    = 1'b0;
        xLoad                     = 1'b0;
        xCountUp                  = 1'b0;
        yCountUp                  = 1'b0;
        addressScreenCounterReset = 1'b0;
        addressSpriteCounterReset = 1'b0;
        count_load                = 1'b0;
        walk_clear                = 1'b0;
        walk_step                 = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    ack      = 1'b1;
                    sprite_d = req_sprite;
                    black_d  = req_erase;
                    mem_d    = req_mem;
                    xsel_d   = req_xsel;
                    ysel_d   = req_ysel;
                    state_d  = INIT;
                end
            end
            INIT: begin
                xInitLoad                 = 1'b1;
                yInitLoad                 = 1'b1;
                xReset                    = 1'b1;
                yReset                    = 1'b1;
                addressSpriteCounterReset = sprite_q;
                addressScreenCounterReset = ~sprite_q;
                walk_clear                = 1'b1;
                prime_d                   = '0;
                state_d                   = PRIME;
            end
            PRIME: begin
                count_load = 1'b1;
                prime_d    = prime_q + 2'd1;
                if (prime_q == 2'(PIPE_LAT - 1)) begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                plot       = 1'b1;
                count_load = 1'b1;
                walk_step  = 1'b1;
                if (col_last) begin
                    xLoad    = 1'b1;
                    yCountUp = 1'b1;
                end else begin
                    xCountUp = 1'b1;
                end
                // Screen end comes from the datapath address counter, sprite end from the walker.
                if (sprite_q ? (col_last && row_last) : screenDone) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        player_reset_d = new_game;
        player_load_d  = ~new_game & (point_p1 ^ point_p2);
        winner1_d      = player_load_d & point_p1;
        winner2_d      = player_load_d & point_p2;
    end

    assign playerReset = player_reset_q;
    assign playerLoad  = player_load_q;
    assign winner1     = winner1_q;
    assign winner2     = winner2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            prime_q        <= '0;
            sprite_q       <= 1'b0;
            black_q        <= 1'b0;
            mem_q          <= '0;
            xsel_q         <= '0;
            ysel_q         <= '0;
            player_reset_q <= 1'b0;
            player_load_q  <= 1'b0;
            winner1_q      <= 1'b0;
            winner2_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            prime_q        <= prime_d;
            sprite_q       <= sprite_d;
            black_q        <= black_d;
            mem_q          <= mem_d;
            xsel_q         <= xsel_d;
            ysel_q         <= ysel_d;
            player_reset_q <= player_reset_d;
            player_load_q  <= player_load_d;
            winner1_q      <= winner1_d;
            winner2_q      <= winner2_d;
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a small datapath model that raises
// screenDone on the last screen pixel.
module tb_draw_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, req_sprite, req_erase;
    logic [4:0] req_mem, req_xsel;
    logic [1:0] req_ysel;
    logic       point_p1, point_p2, new_game;
    logic       screenDone;
    logic       ack, done, busy, plot;
    logic       xInitReset, xInitLoad, yInitReset, yInitLoad;
    logic       xReset, xLoad, xCountUp, yReset, yLoad, yCountUp;
    logic [1:0] xySel;
    logic [4:0] xInitSel;
    logic [1:0] yInitSel;
    logic [4:0] memorySel;
    logic       black;
    logic       addressScreenCounterReset, screenCountLoad;
    logic       addressSpriteCounterReset, spriteCountLoad;
    logic       playerReset, playerLoad, winner1, winner2;

    int vectors     = 0;
    int miscompares = 0;
    int n_plot = 0, n_black = 0, n_ack = 0, n_done = 0, n_wrap = 0;
    int tb_pix = 0;
    int p_plot, p_black, p_ack, p_done, p_wrap;
    logic hit;
    logic [63:0] outs;

    always #5 clk = ~clk;

    assign screenDone = (tb_pix == 19199);

    assign outs = 64'({ack, done, busy, plot, xInitReset, xInitLoad, yInitReset, yInitLoad,
                       xReset, xLoad, xCountUp, yReset, yLoad, yCountUp, xySel, xInitSel,
                       yInitSel, memorySel, black, addressScreenCounterReset, screenCountLoad,
                       addressSpriteCounterReset, spriteCountLoad, playerReset, playerLoad,
                       winner1, winner2});

    draw_sequencer dut (
        .clk                       (clk),
        .reset                     (reset),
        .req                       (req),
        .req_sprite                (req_sprite),
        .req_erase                 (req_erase),
        .req_mem                   (req_mem),
        .req_xsel                  (req_xsel),
        .req_ysel                  (req_ysel),
        .point_p1                  (point_p1),
        .point_p2                  (point_p2),
        .new_game                  (new_game),
        .screenDone                (screenDone),
        .ack                       (ack),
        .done                      (done),
        .busy                      (busy),
        .plot                      (plot),
        .xInitReset                (xInitReset),
        .xInitLoad                 (xInitLoad),
        .yInitReset                (yInitReset),
        .yInitLoad                 (yInitLoad),
        .xReset                    (xReset),
        .xLoad                     (xLoad),
        .xCountUp                  (xCountUp),
        .yReset                    (yReset),
        .yLoad                     (yLoad),
        .yCountUp                  (yCountUp),
        .xySel                     (xySel),
        .xInitSel                  (xInitSel),
        .yInitSel                  (yInitSel),
        .memorySel                 (memorySel),
        .black                     (black),
        .addressScreenCounterReset (addressScreenCounterReset),
        .screenCountLoad           (screenCountLoad),
        .addressSpriteCounterReset (addressSpriteCounterReset),
        .spriteCountLoad           (spriteCountLoad),
        .playerReset               (playerReset),
        .playerLoad                (playerLoad),
        .winner1                   (winner1),
        .winner2                   (winner2)
    );

    // Event counters and the datapath pixel counter behind screenDone.
    always @(posedge clk) begin
        if (ack) tb_pix <= 0;
        else if (plot) tb_pix <= tb_pix + 1;
        if (plot) n_plot <= n_plot + 1;
        if (plot && black) n_black <= n_black + 1;
        if (ack) n_ack <= n_ack + 1;
        if (done) n_done <= n_done + 1;
        if (xLoad && yCountUp) n_wrap <= n_wrap + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic snap();
        p_plot  = n_plot;
        p_black = n_black;
        p_ack   = n_ack;
        p_done  = n_done;
        p_wrap  = n_wrap;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; req_sprite = 1'b0; req_erase = 1'b0;
        req_mem = '0; req_xsel = '0; req_ysel = '0;
        point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs, 64'd0);
        reset = 1'b0;

        // Full screen from ROM 3
        @(negedge clk);
        snap();
        req = 1'b1; req_mem = 5'd3; req_sprite = 1'b0;
        #1 chk("t1_ack", 64'(ack), 64'd1);
        @(negedge clk);
        chk("t1_init_strobes", 64'({ack, busy, xInitLoad, yInitLoad, xReset, yReset,
            addressScreenCounterReset, addressSpriteCounterReset, plot}), 64'b011111100);
        chk("t1_memorySel", 64'(memorySel), 64'd3);
        chk("t1_xySel", 64'(xySel), 64'd0);
        req = 1'b0; req_mem = '0;
        @(negedge clk);
        chk("t1_prime1", 64'({plot, screenCountLoad, spriteCountLoad, xCountUp}), 64'b0100);
        @(negedge clk);
        chk("t1_prime2", 64'({plot, screenCountLoad, spriteCountLoad, xCountUp}), 64'b0100);
        @(negedge clk);
        chk("t1_draw_first", 64'({plot, screenCountLoad, xCountUp, xLoad, yCountUp}), 64'b11100);
        wait_done(20000, hit);
        chk("t1_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_plots", 64'(n_plot - p_plot), 64'd19200);
        chk("t1_dones", 64'(n_done - p_done), 64'd1);
        chk("t1_acks", 64'(n_ack - p_ack), 64'd1);
        chk("t1_row_steps", 64'(n_wrap - p_wrap), 64'd120);

        // Sprite with origin selects 4/2
        snap();
        req = 1'b1; req_sprite = 1'b1; req_xsel = 5'd4; req_ysel = 2'd2; req_mem = 5'd7;
        #1 chk("t2_ack", 64'(ack), 64'd1);
        @(negedge clk);
        chk("t2_init_sel", 64'({xInitSel, yInitSel, xySel, memorySel}), 64'({5'd4, 2'd2, 2'b01, 5'd7}));
        chk("t2_init_rst", 64'({addressScreenCounterReset, addressSpriteCounterReset}), 64'b01);
        req = 1'b0;
        wait_done(2000, hit);
        chk("t2_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("t2_plots", 64'(n_plot - p_plot), 64'd1600);
        chk("t2_row_steps", 64'(n_wrap - p_wrap), 64'd40);
        chk("t2_dones", 64'(n_done - p_done), 64'd1);
        chk("t2_black", 64'(n_black - p_black), 64'd0);

        // req held high through done: one ack each, back-to-back
        snap();
        req = 1'b1;
        #1 chk("t3_ack_first", 64'(ack), 64'd1);
        wait_done(2000, hit);
        chk("t3_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("t3_idle_reack", 64'({busy, ack}), 64'b01);
        chk("t3_acks_first", 64'(n_ack - p_ack), 64'd1);
        @(negedge clk);
        chk("t3_second_init", 64'({busy, xInitLoad}), 64'b11);
        req = 1'b0;
        wait_done(2000, hit);
        chk("t3_done2_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("t3_acks_total", 64'(n_ack - p_ack), 64'd2);
        chk("t3_plots_total", 64'(n_plot - p_plot), 64'd3200);

        // Erased sprite
        snap();
        req = 1'b1; req_erase = 1'b1;
        @(negedge clk);
        chk("t6_black_set", 64'(black), 64'd1);
        req = 1'b0; req_erase = 1'b0;
        wait_done(2000, hit);
        chk("t6_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("t6_black_plots", 64'(n_black - p_black), 64'd1600);

        // Sprite aborted by reset at pixel 500
        snap();
        req = 1'b1;
        @(negedge clk);
        chk("t6_black_clear", 64'(black), 64'd0);
        req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (n_plot - p_plot >= 500) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t4_reached_500", 64'(hit), 64'd1);
        chk("t4_mid_plot", 64'(plot), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_reset_outputs", outs, 64'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_done", 64'(n_done - p_done), 64'd0);
        chk("t4_idle", 64'({busy, plot}), 64'b00);

        // Score strobes
        point_p1 = 1'b1; point_p2 = 1'b1;
        @(negedge clk);
        chk("t5_both", 64'({playerReset, playerLoad, winner1, winner2}), 64'b0000);
        point_p1 = 1'b0; point_p2 = 1'b1;
        @(negedge clk);
        chk("t5_p2", 64'({playerReset, playerLoad, winner1, winner2}), 64'b0101);
        point_p2 = 1'b0; point_p1 = 1'b1; new_game = 1'b1;
        @(negedge clk);
        chk("t5_newgame", 64'({playerReset, playerLoad, winner1, winner2}), 64'b1000);
        point_p1 = 1'b0; new_game = 1'b0;
        @(negedge clk);
        chk("t5_quiet", 64'({playerReset, playerLoad, winner1, winner2}), 64'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
